// File: rtl/sram_port_arbiter.sv
// SRAM port arbiter: shares one external async SRAM between a sample writer
// and an MCU read path, sequencing ram_nwr/ram_nrd with setup/pulse/hold
// timing. Writes win by default; a run counter bounds how many consecutive
// writes may be granted while a read waits.
module sram_port_arbiter #(
   parameter int WR_PULSE   = 2,
   parameter int RD_PULSE   = 3,
   parameter int MAX_WR_RUN = 8
) (
   input  logic        clk,
   input  logic        mcu_n_rst,
   input  logic        wr_req,
   input  logic [19:0] wr_addr,
   input  logic [7:0]  wr_data,
   output logic        wr_ack,
   input  logic        rd_req,
   input  logic [19:0] rd_addr,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        ram_nrd,
   output logic        ram_nwr,
   output logic [19:0] ram_addr,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din,
   output logic        ram_oe
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WR_SETUP = 3'd1;
   localparam logic [2:0] S_WR_PULSE = 3'd2;
   localparam logic [2:0] S_WR_HOLD  = 3'd3;
   localparam logic [2:0] S_RD_PULSE = 3'd4;
   localparam logic [2:0] S_RD_DONE  = 3'd5;

   localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);
   localparam logic [3:0] RD_LOAD = 4'(RD_PULSE - 1);
   localparam logic [7:0] RUN_MAX = 8'(MAX_WR_RUN);

   logic [2:0]  r_state;
   logic [3:0]  r_pcnt;
   logic [7:0]  r_run_cnt;
   logic        r_ram_nrd;
   logic        r_ram_nwr;
   logic        r_ram_oe;
   logic [19:0] r_ram_addr;
   logic [7:0]  r_ram_dout;
   logic [7:0]  r_rd_data;
   logic        r_wr_ack;
   logic        r_rd_valid;
   logic        r_busy;

   logic [2:0]  w_next_state;
   logic        w_grant_wr;
   logic        w_grant_rd;

   // Grant decision in IDLE: write first unless the run limit is reached with a read waiting.
   always_comb begin
      w_grant_wr = 1'b0;
      w_grant_rd = 1'b0;
      if (r_state == S_IDLE) begin
         if (wr_req && (!rd_req || (r_run_cnt < RUN_MAX))) begin
            w_grant_wr = 1'b1;
         end else if (rd_req) begin
            w_grant_rd = 1'b1;
         end else begin
            w_grant_wr = 1'b0;
            w_grant_rd = 1'b0;
         end
      end else begin
         w_grant_wr = 1'b0;
         w_grant_rd = 1'b0;
      end
   end

   // Next-state logic; every access returns to IDLE so a turnaround cycle always follows.
   always_comb begin
      w_next_state = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (w_grant_wr) begin
               w_next_state = S_WR_SETUP;
            end else if (w_grant_rd) begin
               w_next_state = S_RD_PULSE;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_WR_SETUP: w_next_state = S_WR_PULSE;
         S_WR_PULSE: begin
            if (r_pcnt == 4'd0) begin
               w_next_state = S_WR_HOLD;
            end else begin
               w_next_state = S_WR_PULSE;
            end
         end
         S_WR_HOLD:  w_next_state = S_IDLE;
         S_RD_PULSE: begin
            if (r_pcnt == 4'd0) begin
               w_next_state = S_RD_DONE;
            end else begin
               w_next_state = S_RD_PULSE;
            end
         end
         S_RD_DONE:  w_next_state = S_IDLE;
         default:    w_next_state = S_IDLE;
      endcase
   end

   // State, counters and registered SRAM/handshake outputs derived from the next state.
   always_ff @(posedge clk or negedge mcu_n_rst) begin
      if (!mcu_n_rst) begin
         r_state    <= S_IDLE;
         r_pcnt     <= 4'd0;
         r_run_cnt  <= 8'd0;
         r_ram_nrd  <= 1'b1;
         r_ram_nwr  <= 1'b1;
         r_ram_oe   <= 1'b0;
         r_ram_addr <= 20'd0;
         r_ram_dout <= 8'd0;
         r_rd_data  <= 8'd0;
         r_wr_ack   <= 1'b0;
         r_rd_valid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_busy     <= (w_next_state != S_IDLE);
         r_wr_ack   <= (w_next_state == S_WR_HOLD);
         r_rd_valid <= (w_next_state == S_RD_DONE);
         r_ram_nwr  <= (w_next_state != S_WR_PULSE);
         r_ram_nrd  <= (w_next_state != S_RD_PULSE);
         r_ram_oe   <= (w_next_state == S_WR_SETUP) || (w_next_state == S_WR_PULSE) ||
                       (w_next_state == S_WR_HOLD);

         if (w_grant_wr) begin
            r_ram_addr <= wr_addr;
            r_ram_dout <= wr_data;
            if (!rd_req) begin
               r_run_cnt <= 8'd0;
            end else if (r_run_cnt != 8'hFF) begin
               r_run_cnt <= r_run_cnt + 8'd1;
            end
         end else if (w_grant_rd) begin
            r_ram_addr <= rd_addr;
            r_run_cnt  <= 8'd0;
         end

         if (r_state == S_WR_SETUP) begin
            r_pcnt <= WR_LOAD;
         end else if (w_grant_rd) begin
            r_pcnt <= RD_LOAD;
         end else if (((r_state == S_WR_PULSE) || (r_state == S_RD_PULSE)) && (r_pcnt != 4'd0)) begin
            r_pcnt <= r_pcnt - 4'd1;
         end

         // Data is sampled at the edge that ends the final read-pulse cycle.
         if ((r_state == S_RD_PULSE) && (r_pcnt == 4'd0)) begin
            r_rd_data <= ram_din;
         end
      end
   end

   assign wr_ack   = r_wr_ack;
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign busy     = r_busy;
   assign ram_nrd  = r_ram_nrd;
   assign ram_nwr  = r_ram_nwr;
   assign ram_oe   = r_ram_oe;
   assign ram_addr = r_ram_addr;
   assign ram_dout = r_ram_dout;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM model
// (write on rising ram_nwr, combinational read data).
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        mcu_n_rst = 1'b0;
   logic        wr_req = 1'b0;
   logic [19:0] wr_addr = 20'd0;
   logic [7:0]  wr_data = 8'd0;
   logic        wr_ack;
   logic        rd_req = 1'b0;
   logic [19:0] rd_addr = 20'd0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        busy;
   logic        ram_nrd;
   logic        ram_nwr;
   logic [19:0] ram_addr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic        ram_oe;

   int checks = 0;
   int errors = 0;
   logic [7:0] mem [256];
   logic [7:0] sh  [256];

   sram_port_arbiter #(.WR_PULSE(2), .RD_PULSE(3), .MAX_WR_RUN(8)) dut (
      .clk(clk), .mcu_n_rst(mcu_n_rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .busy(busy), .ram_nrd(ram_nrd), .ram_nwr(ram_nwr), .ram_addr(ram_addr),
      .ram_dout(ram_dout), .ram_din(ram_din), .ram_oe(ram_oe)
   );

   always #5 clk = ~clk;

   // SRAM model: latch data on the rising edge of the write strobe.
   always @(posedge ram_nwr) begin
      if (mcu_n_rst) mem[ram_addr[7:0]] <= ram_dout;
   end

   assign ram_din = mem[ram_addr[7:0]];

   task automatic test_reset();
      mcu_n_rst = 1'b0;
      #12;
      checks++;
      if ({ram_nrd, ram_nwr, ram_oe} !== 3'b110) begin
         errors++; $display("FAIL reset_strobes: got %b expected 110", {ram_nrd, ram_nwr, ram_oe});
      end
      checks++;
      if ({ram_addr, ram_dout, rd_data} !== 36'd0) begin
         errors++; $display("FAIL reset_regs: got addr %h dout %h rd_data %h expected zeros", ram_addr, ram_dout, rd_data);
      end
      checks++;
      if ({wr_ack, rd_valid, busy} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b expected 000", {wr_ack, rd_valid, busy});
      end
      @(negedge clk);
      mcu_n_rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_single_write();
      logic [4:0] exp_v [5];
      logic [4:0] obs;
      // {ram_oe, ram_nwr, ram_nrd, wr_ack, busy}
      exp_v = '{5'b11101, 5'b10101, 5'b10101, 5'b11111, 5'b01100};
      wr_addr = 20'h12345; wr_data = 8'hA5; wr_req = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         obs = {ram_oe, ram_nwr, ram_nrd, wr_ack, busy};
         checks++;
         if (obs !== exp_v[c]) begin
            errors++; $display("FAIL single_write cycle %0d: got %b expected %b", c + 1, obs, exp_v[c]);
         end
         if (c == 1) begin
            checks++;
            if ({ram_addr, ram_dout} !== {20'h12345, 8'hA5}) begin
               errors++; $display("FAIL single_write_addr_data: got %h/%h expected 12345/a5", ram_addr, ram_dout);
            end
         end
         if (wr_ack) wr_req = 1'b0;
      end
      checks++;
      if (mem[8'h45] !== 8'hA5) begin
         errors++; $display("FAIL single_write_mem: got %h expected a5", mem[8'h45]);
      end
   endtask

   task automatic test_single_read();
      logic [4:0] exp_v [5];
      logic [4:0] obs;
      // {ram_oe, ram_nwr, ram_nrd, rd_valid, busy}
      exp_v = '{5'b01001, 5'b01001, 5'b01001, 5'b01111, 5'b01100};
      rd_addr = 20'h00010; rd_req = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         obs = {ram_oe, ram_nwr, ram_nrd, rd_valid, busy};
         checks++;
         if (obs !== exp_v[c]) begin
            errors++; $display("FAIL single_read cycle %0d: got %b expected %b", c + 1, obs, exp_v[c]);
         end
         if (c == 0) begin
            checks++;
            if (ram_addr !== 20'h00010) begin
               errors++; $display("FAIL single_read_addr: got %h expected 00010", ram_addr);
            end
         end
         if (c >= 3) begin
            checks++;
            if (rd_data !== 8'h3C) begin
               errors++; $display("FAIL single_read_data cycle %0d: got %h expected 3c", c + 1, rd_data);
            end
         end
         if (rd_valid) rd_req = 1'b0;
      end
   endtask

   task automatic test_simultaneous();
      int ack_c = -1;
      int val_c = -1;
      int viol = 0;
      logic [7:0] got = 8'h00;
      wr_addr = 20'h00020; wr_data = 8'h5A; rd_addr = 20'h00045;
      wr_req = 1'b1; rd_req = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (!ram_nrd && (!ram_nwr || ram_oe)) viol++;
         if (wr_ack) begin ack_c = c; wr_req = 1'b0; end
         if (rd_valid) begin val_c = c; got = rd_data; rd_req = 1'b0; end
      end
      checks++;
      if (ack_c != 4) begin
         errors++; $display("FAIL simul_write_first: ack cycle %0d expected 4", ack_c);
      end
      checks++;
      if (val_c != 9) begin
         errors++; $display("FAIL simul_read_after: valid cycle %0d expected 9", val_c);
      end
      checks++;
      if (got !== 8'hA5) begin
         errors++; $display("FAIL simul_read_data: got %h expected a5", got);
      end
      checks++;
      if (viol != 0) begin
         errors++; $display("FAIL simul_strobe_excl: violations %0d expected 0", viol);
      end
   endtask

   task automatic test_starvation();
      int acks = 0, acks_before = 0, a1 = -1, a2 = -1, val_c = -1, first_after = -1;
      logic [7:0] run_after = 8'hFF;
      logic [7:0] got = 8'h00;
      logic read_seen = 1'b0;
      wr_addr = 20'h00030; wr_data = 8'h11; rd_addr = 20'h00010;
      wr_req = 1'b1; rd_req = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (wr_ack) begin
            acks++;
            if (!read_seen) acks_before++;
            if (acks == 1) a1 = c;
            if (acks == 2) a2 = c;
            if (read_seen) begin first_after = c; wr_req = 1'b0; break; end
         end
         if (rd_valid) begin
            read_seen = 1'b1; val_c = c; got = rd_data; rd_req = 1'b0;
            run_after = dut.r_run_cnt;
         end
      end
      wr_req = 1'b0; rd_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (acks_before != 8) begin
         errors++; $display("FAIL starve_run_len: acks before read %0d expected 8", acks_before);
      end
      checks++;
      if ((a2 - a1) != 5) begin
         errors++; $display("FAIL back_to_back_spacing: got %0d expected 5", a2 - a1);
      end
      checks++;
      if (run_after !== 8'd0) begin
         errors++; $display("FAIL starve_run_cnt_clear: got %0d expected 0", run_after);
      end
      checks++;
      if (got !== 8'h3C) begin
         errors++; $display("FAIL starve_read_data: got %h expected 3c", got);
      end
      checks++;
      if ((val_c < 0) || ((first_after - val_c) != 5)) begin
         errors++; $display("FAIL starve_write_resume: valid %0d next ack %0d expected gap 5", val_c, first_after);
      end
   endtask

   task automatic test_reset_mid_write();
      int ack_seen = 0;
      int ack_c = -1;
      wr_addr = 20'h00099; wr_data = 8'h77; wr_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #2;
      mcu_n_rst = 1'b0;
      #1;
      checks++;
      if ({ram_nwr, ram_oe, busy} !== 3'b100) begin
         errors++; $display("FAIL reset_abort_async: nwr/oe/busy got %b expected 100", {ram_nwr, ram_oe, busy});
      end
      wr_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (wr_ack) ack_seen++;
      end
      mcu_n_rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (wr_ack) ack_seen++;
      end
      checks++;
      if (ack_seen != 0) begin
         errors++; $display("FAIL reset_abort_no_ack: acks %0d expected 0", ack_seen);
      end
      wr_addr = 20'h00077; wr_data = 8'hC3; wr_req = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (wr_ack && (ack_c < 0)) begin ack_c = c; wr_req = 1'b0; end
      end
      checks++;
      if (ack_c != 4) begin
         errors++; $display("FAIL reset_fresh_write: ack cycle %0d expected 4", ack_c);
      end
      checks++;
      if (mem[8'h77] !== 8'hC3) begin
         errors++; $display("FAIL reset_fresh_mem: got %h expected c3", mem[8'h77]);
      end
   endtask

   task automatic test_random();
      int wr_iss = 0, wr_acks = 0, rd_iss = 0, rd_vals = 0, viol = 0;
      for (int i = 0; i < 256; i++) sh[i] = mem[i];
      for (int cyc = 0; cyc < 10060; cyc++) begin
         @(negedge clk);
         if (!ram_nrd && (!ram_nwr || ram_oe)) viol++;
         if (wr_ack) begin
            wr_acks++; sh[wr_addr[7:0]] = wr_data; wr_req = 1'b0;
         end else if (!wr_req && (cyc < 10000) && ($urandom_range(3) == 0)) begin
            wr_addr = 20'($urandom); wr_data = 8'($urandom); wr_req = 1'b1; wr_iss++;
         end
         if (rd_valid) begin
            rd_vals++;
            checks++;
            if (rd_data !== sh[rd_addr[7:0]]) begin
               errors++; $display("FAIL random_read_data addr %h: got %h expected %h", rd_addr, rd_data, sh[rd_addr[7:0]]);
            end
            rd_req = 1'b0;
         end else if (!rd_req && (cyc < 10000) && ($urandom_range(3) == 0)) begin
            rd_addr = 20'($urandom); rd_req = 1'b1; rd_iss++;
         end
      end
      checks++;
      if (viol != 0) begin
         errors++; $display("FAIL random_strobe_excl: violations %0d expected 0", viol);
      end
      checks++;
      if (wr_acks != wr_iss) begin
         errors++; $display("FAIL random_wr_acks: got %0d expected %0d", wr_acks, wr_iss);
      end
      checks++;
      if (rd_vals != rd_iss) begin
         errors++; $display("FAIL random_rd_valids: got %0d expected %0d", rd_vals, rd_iss);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[16] = 8'h3C;
      test_reset();
      test_single_write();
      test_single_read();
      test_simultaneous();
      test_starvation();
      test_reset_mid_write();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single external async SRAM (ram_nrd/ram_nwr/ram_addr/ram_data) between two requesters.
  - Sample writer: streams captured encoder bytes into SRAM.
  - MCU read path: fetches stored bytes on mcu_rd_clk-derived requests.
- Sequences SRAM strobes with programmable setup/pulse/hold timing.
- Writes get priority; a starvation guard ensures reads still progress.
- Sits between the sampling and MCU-read logic and the top-level ram_* pins. The top level owns the tristate buffer, controlled by ram_oe.

Parameters:
WR_PULSE, 2, cycles ram_nwr held low (1..15)
RD_PULSE, 3, cycles ram_nrd held low before data capture (1..15)
MAX_WR_RUN, 8, consecutive write grants allowed while a read is pending (1..255)

Ports:
clk  in  1  system clock
mcu_n_rst  in  1  asynchronous active-low reset
wr_req  in  1  write request; held high until wr_ack
wr_addr  in  20  write address; stable while wr_req high
wr_data  in  8  write data; stable while wr_req high
wr_ack  out  1  1-cycle pulse: write completed
rd_req  in  1  read request; held high until rd_valid
rd_addr  in  20  read address; stable while rd_req high
rd_data  out  8  captured read byte; holds until next read
rd_valid  out  1  1-cycle pulse: rd_data updated
busy  out  1  high in any state other than IDLE
ram_nrd  out  1  SRAM read strobe, active low
ram_nwr  out  1  SRAM write strobe, active low
ram_addr  out  20  SRAM address
ram_dout  out  8  data to SRAM; top drives ram_data when ram_oe=1
ram_din  in  8  ram_data pin value
ram_oe  out  1  output enable for ram_data tristate

Behaviour:
- Reset (async, mcu_n_rst=0):
  - Immediately: ram_nrd=1, ram_nwr=1, ram_oe=0, state=IDLE.
  - Cleared: ram_addr=0, ram_dout=0, rd_data=0, wr_ack=0, rd_valid=0, busy=0, pulse counter=0, run counter=0.
  - Reset mid-access aborts the access; no ack/valid is issued for it.
- All outputs are registered; no combinational path from request inputs to outputs.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_PULSE, RD_DONE.
- IDLE grant decision, evaluated each cycle:
  - Only wr_req high -> WR_SETUP.
  - Only rd_req high -> RD_PULSE.
  - Both high -> WR_SETUP if run_cnt < MAX_WR_RUN, else RD_PULSE.
  - Neither high -> stay in IDLE.
- run_cnt (8 bit):
  - +1 on each write grant while rd_req is high; saturates at 255.
  - Cleared on every read grant and whenever rd_req is low at a grant.
- Write sequence:
  - WR_SETUP, 1 cycle: ram_addr=wr_addr, ram_dout=wr_data, ram_oe=1, ram_nwr=1.
  - WR_PULSE, WR_PULSE cycles: ram_nwr=0; addr/data held.
  - WR_HOLD, 1 cycle: ram_nwr=1, ram_oe still 1, addr/data held; wr_ack=1.
  - Then IDLE with ram_oe=0.
  - Total WR_PULSE+2 cycles; grant-to-ack latency WR_PULSE+2 cycles.
- Read sequence:
  - RD_PULSE, RD_PULSE cycles: ram_addr=rd_addr, ram_oe=0, ram_nrd=0.
  - At the clock edge ending the last RD_PULSE cycle: rd_data<=ram_din.
  - RD_DONE, 1 cycle: ram_nrd=1, rd_valid=1.
  - Then IDLE.
- Strobe exclusion: ram_nrd and ram_nwr are never low simultaneously. ram_oe is never 1 while ram_nrd=0.
- Turnaround: at least one IDLE cycle between any two accesses, with ram_oe=0 in that cycle. Back-to-back writes therefore take WR_PULSE+3 cycles each.
- Ack timing: wr_ack and rd_valid are single-cycle pulses. A requester that keeps its request high on the cycle after the ack is treated as a new request.
- Pulse counter: 4 bit, loaded with PULSE-1, counts down to 0.
- ram_addr keeps its last value in IDLE.

Test Plan:
- Single write: wr_addr=0x12345, wr_data=0xA5, WR_PULSE=2 -> exact sequence:
  - 1 setup cycle: ram_oe=1, ram_nwr=1.
  - 2 cycles: ram_nwr=0, ram_addr=0x12345, ram_dout=0xA5.
  - 1 hold cycle: wr_ack=1.
  - Then ram_oe=0.
- Single read: rd_addr=0x00010, ram_din model returns 0x3C, RD_PULSE=3 -> ram_nrd=0 for 3 cycles; rd_valid pulses in the next cycle with rd_data=0x3C; ram_oe stays 0 throughout.
- Simultaneous first requests (wr_req and rd_req rise together) -> write granted first. Read granted immediately after the write plus 1 IDLE cycle.
- Continuous wr_req with rd_req pending, MAX_WR_RUN=8 -> exactly 8 write acks, then 1 read, then writes resume; run_cnt is 0 after the read.
- mcu_n_rst asserted during the 2nd WR_PULSE cycle:
  - Same cycle (asynchronous): ram_nwr=1, ram_oe=0.
  - No wr_ack.
  - After release, a fresh write completes normally.
- Assertion, over a random request stream of 10k cycles:
  - Never ram_nrd=0 together with ram_nwr=0 or ram_oe=1.
  - Ack/valid count equals grants.
